// File: rtl/vga_term_pkg.sv
// Shared types and constants for the VGA terminal writer.
// Build option: define VGA_TERM_SPLASH_EN to defer the display-select write until first output.
package vga_term_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_NORMAL,
    S_ESC,
    S_CSI,
    S_CUP,
    S_CLR
  } state_t;

  // Sub-step inside the multi-write states (cursor move and clear screen).
  typedef enum logic [2:0] {
    PH_Y,
    PH_X,
    PH_FILL,
    PH_Y0,
    PH_X0
  } phase_t;

  localparam logic [2:0] A_CHAR = 3'b000;
  localparam logic [2:0] A_CURX = 3'b001;
  localparam logic [2:0] A_CURY = 3'b011;
  localparam logic [2:0] A_DSEL = 3'b110;

  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [7:0] CH_LBRACKET = 8'h5B;
  localparam logic [7:0] CH_SEMI     = 8'h3B;
  localparam logic [7:0] CH_H        = 8'h48;
  localparam logic [7:0] CH_F        = 8'h66;
  localparam logic [7:0] CH_J        = 8'h4A;
  localparam logic [7:0] CH_0        = 8'h30;
  localparam logic [7:0] CH_9        = 8'h39;

`ifdef VGA_TERM_SPLASH_EN
  localparam bit SPLASH_EN = 1'b1;
`else
  localparam bit SPLASH_EN = 1'b0;
`endif

  // Decimal accumulate with saturation at 255.
  function automatic logic [7:0] mac10(input logic [7:0] p, input logic [3:0] d);
    logic [11:0] acc;
    acc = 12'(p) * 12'd10 + 12'(d);
    return (acc > 12'd255) ? 8'hFF : acc[7:0];
  endfunction

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) || (b == CR) || (b == LF);
  endfunction

endpackage

// File: rtl/vga_term_fifo.sv
// Synchronous byte FIFO with registered full/empty and first-word-fall-through read port.
module vga_term_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_d;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_d = count;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count + (AW + 1)'(1);
      2'b01:   count_d = count - (AW + 1)'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == FULL_CNT);
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_term_writer.sv
// Byte-stream terminal front end: FIFO + minimal ANSI parser driving vga_char's write port.
// Build option: VGA_TERM_SPLASH_EN (see vga_term_pkg).
module vga_term_writer
  import vga_term_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int COLS       = 64,
  parameter int ROWS       = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_ready_o,
  output logic       wb_cyc_o,
  output logic       wb_we_o,
  output logic [2:0] wb_addr_o,
  output logic [7:0] wb_dat_o,
  output logic       busy_o
);

  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
  localparam logic [7:0] COL_MAX = 8'(COLS - 1);
  localparam state_t RESET_STATE = SPLASH_EN ? S_NORMAL : S_INIT;

  state_t     state_q, state_d;
  phase_t     ph_q, ph_d;
  logic [7:0] p0_q, p0_d, p1_q, p1_d;
  logic       idx_q, idx_d;
  logic [7:0] row_q, row_d, col_q, col_d;
  logic       splash_q, splash_d;
  logic       cyc_q;
  logic [2:0] addr_q;
  logic [7:0] dat_q;

  logic       issue;
  logic [2:0] addr;
  logic [7:0] dat;
  logic       pop;
  logic       push;
  logic [7:0] head;
  logic       full;
  logic       empty;
  logic [7:0] cup_row, cup_col;

  // Handshake: a byte transfers on a rising edge where rx_valid_i and rx_ready_o are both high;
  // rx_ready_o depends only on the registered full flag (and reset), never on rx_valid_i.
  assign rx_ready_o = ~full & ~rst_i;
  assign push       = rx_valid_i & rx_ready_o;

  vga_term_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .din   (rx_data_i),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    cup_row = (p0_q == 8'd0) ? 8'd0 : p0_q - 8'd1;
    cup_col = (p1_q == 8'd0) ? 8'd0 : p1_q - 8'd1;
    if (cup_row > ROW_MAX) cup_row = ROW_MAX;
    if (cup_col > COL_MAX) cup_col = COL_MAX;
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    p0_d     = p0_q;
    p1_d     = p1_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    splash_d = splash_q;
    issue    = 1'b0;
    addr     = A_CHAR;
    dat      = 8'h00;
    pop      = 1'b0;
    unique case (state_q)
      S_INIT: begin
        issue   = 1'b1;
        addr    = A_DSEL;
        state_d = S_NORMAL;
      end
      S_NORMAL: begin
        if (!empty) begin
          if (is_text(head)) begin
            issue = 1'b1;
            if (splash_q) begin
              // Leave the byte in the FIFO; it is written next cycle.
              addr     = A_DSEL;
              splash_d = 1'b0;
            end else begin
              addr = A_CHAR;
              dat  = head;
              pop  = 1'b1;
            end
          end else begin
            pop = 1'b1;
            if (head == ESC) state_d = S_ESC;
          end
        end
      end
      S_ESC: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == CH_LBRACKET) begin
            p0_d    = 8'd0;
            p1_d    = 8'd0;
            idx_d   = 1'b0;
            state_d = S_CSI;
          end else begin
            state_d = S_NORMAL;
          end
        end
      end
      S_CSI: begin
        if (!empty) begin
          pop = 1'b1;
          if (head >= CH_0 && head <= CH_9) begin
            if (idx_q) p1_d = mac10(p1_q, head[3:0]);
            else       p0_d = mac10(p0_q, head[3:0]);
          end else if (head == CH_SEMI) begin
            idx_d = 1'b1;
          end else if (head == CH_H || head == CH_F) begin
            ph_d    = PH_Y;
            state_d = S_CUP;
          end else if (head == CH_J && p0_q == 8'd2) begin
            ph_d    = PH_Y;
            row_d   = 8'd0;
            col_d   = 8'd0;
            state_d = S_CLR;
          end else begin
            state_d = S_NORMAL;
          end
        end
      end
      S_CUP: begin
        issue = 1'b1;
        if (ph_q == PH_Y) begin
          addr = A_CURY;
          dat  = cup_row;
          ph_d = PH_X;
        end else begin
          addr    = A_CURX;
          dat     = cup_col;
          state_d = S_NORMAL;
        end
      end
      S_CLR: begin
        issue = 1'b1;
        if (splash_q) begin
          addr     = A_DSEL;
          splash_d = 1'b0;
        end else begin
          unique case (ph_q)
            PH_Y: begin
              addr = A_CURY;
              dat  = row_q;
              ph_d = PH_X;
            end
            PH_X: begin
              addr  = A_CURX;
              col_d = 8'd0;
              ph_d  = PH_FILL;
            end
            PH_FILL: begin
              addr = A_CHAR;
              dat  = SPACE;
              if (col_q == COL_MAX) begin
                col_d = 8'd0;
                if (row_q == ROW_MAX) begin
                  ph_d = PH_Y0;
                end else begin
                  row_d = row_q + 8'd1;
                  ph_d  = PH_Y;
                end
              end else begin
                col_d = col_q + 8'd1;
              end
            end
            PH_Y0: begin
              addr = A_CURY;
              ph_d = PH_X0;
            end
            PH_X0: begin
              addr    = A_CURX;
              state_d = S_NORMAL;
            end
            default: begin
              issue   = 1'b0;
              state_d = S_NORMAL;
            end
          endcase
        end
      end
      default: state_d = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RESET_STATE;
      ph_q     <= PH_Y;
      p0_q     <= 8'd0;
      p1_q     <= 8'd0;
      idx_q    <= 1'b0;
      row_q    <= 8'd0;
      col_q    <= 8'd0;
      splash_q <= SPLASH_EN;
      cyc_q    <= 1'b0;
      addr_q   <= 3'b000;
      dat_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      splash_q <= splash_d;
      cyc_q    <= issue;
      if (issue) begin
        addr_q <= addr;
        dat_q  <= dat;
      end
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_we_o   = cyc_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign busy_o    = (state_q != S_NORMAL) | ~empty | cyc_q;

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer: expected bus writes queued as stimulus is sent, checked as they appear.
module tb_vga_term_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       wb_cyc;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_dat;
  logic       busy;

  logic [10:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  bit mon_skip = 1'b0;

  always #5 clk = ~clk;

  vga_term_writer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready),
    .wb_cyc_o   (wb_cyc),
    .wb_we_o    (wb_we),
    .wb_addr_o  (wb_addr),
    .wb_dat_o   (wb_dat),
    .busy_o     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (wb_cyc === 1'b1 && !mon_skip) begin
      if (exp_q.size() == 0) check("unexpected_write", {21'b0, wb_addr, wb_dat}, 32'hFFFF_FFFF);
      else                   check("bus_write", {21'b0, wb_addr, wb_dat}, {21'b0, exp_q.pop_front()});
      check("we_eq_cyc", {31'b0, wb_we}, 32'd1);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_we", {31'b0, wb_we}, 32'd0);
    check("rst_addr", {29'b0, wb_addr}, 32'd0);
    check("rst_dat", {24'b0, wb_dat}, 32'd0);
    check("rst_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);

    // Power-up display select on the first cycle after reset.
    push_exp(3'b110, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, rx_ready}, 32'd1);
    check("init_cyc", {31'b0, wb_cyc}, 32'd1);
    check("init_addr", {29'b0, wb_addr}, 32'd6);
    @(negedge clk);
    check("busy_after_init", {31'b0, busy}, 32'd0);
    wait_idle(20);

    // "Hi" back to back: first write visible two edges after accept, then one per cycle.
    push_exp(3'b000, 8'h48);
    push_exp(3'b000, 8'h69);
    rx_valid = 1'b1;
    rx_data  = 8'h48;
    @(posedge clk);
    @(negedge clk);
    check("hi_lat_early", {31'b0, wb_cyc}, 32'd0);
    rx_data = 8'h69;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    check("hi_first", {23'b0, wb_cyc, wb_dat}, {23'b0, 1'b1, 8'h48});
    @(negedge clk);
    check("hi_second", {23'b0, wb_cyc, wb_dat}, {23'b0, 1'b1, 8'h69});
    wait_idle(20);

    // Cursor positioning, including clamping and defaulted parameters.
    push_exp(3'b011, 8'h04);
    push_exp(3'b001, 8'h09);
    send(8'h1B);
    send_str("[5;10H");
    wait_idle(50);
    push_exp(3'b011, 8'h1F);
    push_exp(3'b001, 8'h3F);
    send(8'h1B);
    send_str("[99;200H");
    wait_idle(50);
    push_exp(3'b011, 8'h00);
    push_exp(3'b001, 8'h00);
    send(8'h1B);
    send_str("[H");
    wait_idle(50);

    // Aborted sequences write nothing; normal text resumes.
    send(8'h1B);
    send_str("[3J");
    send(8'h1B);
    send_str("X");
    wait_idle(50);
    push_exp(3'b000, 8'h41);
    send_str("A");
    wait_idle(20);

    // Control bytes: BEL dropped, CR and LF written.
    push_exp(3'b000, 8'h0D);
    push_exp(3'b000, 8'h0A);
    send(8'h07);
    send(8'h0D);
    send(8'h0A);
    wait_idle(20);

    // Full clear with input buffered during the clear.
    for (int r = 0; r < 32; r++) begin
      push_exp(3'b011, 8'(r));
      push_exp(3'b001, 8'h00);
      for (int c = 0; c < 64; c++) push_exp(3'b000, 8'h20);
    end
    push_exp(3'b011, 8'h00);
    push_exp(3'b001, 8'h00);
    for (int i = 0; i < 16; i++) push_exp(3'b000, 8'(8'h61 + i));
    check("clear_exp_count", exp_q.size(), 32'd2130);
    send(8'h1B);
    send_str("[2J");
    for (int i = 0; i < 16; i++) send(8'(8'h61 + i));
    check("ready_full", {31'b0, rx_ready}, 32'd0);
    check("busy_clear", {31'b0, busy}, 32'd1);
    wait_idle(5000);

    // Reset in the middle of a clear stops bus activity at once.
    mon_skip = 1'b1;
    send(8'h1B);
    send_str("[2J");
    repeat (50) @(negedge clk);
    check("clear_active", {31'b0, wb_cyc}, 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_quiet", {31'b0, wb_cyc}, 32'd0);
    end
    mon_skip = 1'b0;
    push_exp(3'b110, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("reinit_cyc", {31'b0, wb_cyc}, 32'd1);
    wait_idle(20);
    push_exp(3'b000, 8'h5A);
    send_str("Z");
    wait_idle(20);

    check("final_queue", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
